parent_server: RTL and testbench
================================

// Module: parent_server
// PURPOSE
//   Upstream stage of the kid FSM: consumes its request line and produces the meal and book pulses it waits on.
//   Keeps a small pantry stock, cooks for a fixed time, serves a meal, then hands over a book after a delay.
//   Paces the kid's hungry -> full -> study -> hungry cycle and exposes pantry and status signals to the top level.
// PARAMETERS
//   COOK_CYCLES   4   cycles spent in COOK before serving (>=1)
//   BOOK_DELAY    2   cycles between meal pulse and book pulse (>=1)
//   PANTRY_DEPTH  3   max stored ingredients (1..2**CNT_W-1)
//   INIT_STOCK    1   pantry count after reset (<=PANTRY_DEPTH)
//   CNT_W         4   width of pantry/cook/delay counters
//   STARVE_LIMIT  8   cycles of unserved request before alarm (STARVE_ALARM_EN only)
// PORTS
//   clk         in   1      rising-edge clock
//   resetb      in   1      asynchronous reset, ACTIVE-HIGH despite name (fixed decision)
//   request     in   1      kid asks for food (level, registered in kid)
//   groceries   in   1      1-cycle pulse: one ingredient delivered
//   meal        out  1      1-cycle pulse: meal served to kid
//   book        out  1      1-cycle pulse: book handed to kid
//   pantry_cnt  out  CNT_W  current ingredient count
//   busy        out  1      high whenever state != IDLE
//   drop        out  1      1-cycle pulse: grocery discarded, pantry full
//   starving    out  1      sticky alarm (STARVE_ALARM_EN only; else tied 0)
// BEHAVIOUR
//   Reset (resetb=1, async): state=IDLE, pantry_cnt=INIT_STOCK, meal=book=drop=starving=0, counters cleared.
//   All outputs registered; every transition on posedge clk.
//   FSM states: IDLE, COOK, SERVE, WAIT, READ.
//   IDLE: request=1 && pantry_cnt>0 -> COOK; cook_cnt<=COOK_CYCLES-1; pantry_cnt decremented same edge.
//         request=1 && pantry_cnt==0 -> stay IDLE (no cooking without stock).
//   COOK: cook_cnt decrements each cycle; at cook_cnt==0 -> SERVE. request ignored.
//   SERVE: meal=1 exactly this cycle; -> WAIT, dly_cnt<=BOOK_DELAY-1.
//   WAIT: dly_cnt decrements; at 0 -> READ.
//   READ: book=1 exactly this cycle; -> IDLE.
//   Latency: request sampled high in IDLE -> meal high COOK_CYCLES+1 cycles later; book BOOK_DELAY+1 after meal.
//   Pantry: groceries pulse adds 1 on any state; consume+groceries same edge -> count unchanged.
//     groceries at count==PANTRY_DEPTH and no consume -> count held, drop=1 one cycle.
//     Count never wraps; never below 0.
//   No re-serve: request is ignored outside IDLE; kid's request falls after meal, so IDLE after READ sees request=0
//     until kid returns to hungry state.
//   Reset mid-operation: any state -> IDLE immediately; pending meal/book pulses are cancelled; consumed stock not restored.
// CONFIGURATION
//   STARVE_ALARM_EN defined: starve_cnt (CNT_W) increments each cycle state==IDLE && request==1 && pantry_cnt==0,
//     saturating; clears when that condition drops. starve_cnt reaching STARVE_LIMIT sets starving=1 (sticky).
//     starving clears only on reset or on a meal pulse.
//   STARVE_ALARM_EN undefined: no starve counter; starving driven constant 0.
// TESTING
//   Reset, INIT_STOCK=1, request=1 from cycle 2 -> COOK entered, pantry_cnt 1->0, meal pulse 5 cycles after entering COOK, book 3 later.
//   Full loop with kid instance, groceries pulse every 10 cycles -> alternating meal/book, no double meal per request.
//   pantry_cnt=0, request=1 for 20 cycles -> meal stays 0, busy=0; then groceries pulse -> COOK next edge.
//   pantry_cnt=3, groceries pulse in IDLE -> drop=1 one cycle, count stays 3; groceries on consume edge -> count stays 3.
//   Assert resetb during WAIT -> state IDLE, book never pulses, pantry_cnt=INIT_STOCK.
//   STARVE_ALARM_EN: empty pantry, request=1 for 8 cycles -> starving=1; stock+meal -> starving=0.

Source files
------------

// File: rtl/parent_server.sv
// parent_server: upstream stage of the kid FSM.
// Holds a small pantry, cooks for COOK_CYCLES, emits a one-cycle meal pulse,
// then a one-cycle book pulse BOOK_DELAY+1 cycles later.
// resetb is an asynchronous, ACTIVE-HIGH reset despite its name.
// Optional feature macro: STARVE_ALARM_EN (sticky starvation alarm).
module parent_server #(
   parameter int COOK_CYCLES  = 4,
   parameter int BOOK_DELAY   = 2,
   parameter int PANTRY_DEPTH = 3,
   parameter int INIT_STOCK   = 1,
   parameter int CNT_W        = 4,
   parameter int STARVE_LIMIT = 8
) (
   input  logic             clk,
   input  logic             resetb,
   input  logic             request,
   input  logic             groceries,
   output logic             meal,
   output logic             book,
   output logic [CNT_W-1:0] pantry_cnt,
   output logic             busy,
   output logic             drop,
   output logic             starving
);

   typedef enum logic [2:0] {IDLE, COOK, SERVE, WAIT, READ} state_t;

   localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
   localparam logic [CNT_W-1:0] COOK_LOAD = CNT_W'(COOK_CYCLES - 1);
   localparam logic [CNT_W-1:0] DLY_LOAD  = CNT_W'(BOOK_DELAY - 1);
   localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(PANTRY_DEPTH);
   localparam logic [CNT_W-1:0] INIT_C    = CNT_W'(INIT_STOCK);

   // Elaboration-time sanity of the parameter set
   if (COOK_CYCLES < 1 || BOOK_DELAY < 1 || PANTRY_DEPTH < 1 ||
       PANTRY_DEPTH > (2**CNT_W) - 1 || INIT_STOCK > PANTRY_DEPTH ||
       STARVE_LIMIT < 1 || STARVE_LIMIT > (2**CNT_W) - 1) begin : g_bad_params
      $error("parent_server: illegal parameter combination");
   end

   state_t           state;
   logic [CNT_W-1:0] cook_cnt;
   logic [CNT_W-1:0] dly_cnt;
   logic             consume;
   logic             full;

   // A meal can only start from IDLE with stock on hand
   assign consume = (state == IDLE) && request && (pantry_cnt != '0);
   assign full    = (pantry_cnt == DEPTH_C);

   // Serving FSM with registered meal/book/busy outputs
   always_ff @(posedge clk or posedge resetb) begin
      if (resetb) begin
         state    <= IDLE;
         cook_cnt <= '0;
         dly_cnt  <= '0;
         meal     <= 1'b0;
         book     <= 1'b0;
         busy     <= 1'b0;
      end else begin
         meal <= 1'b0;
         book <= 1'b0;
         case (state)
            IDLE: begin
               if (consume) begin
                  state    <= COOK;
                  cook_cnt <= COOK_LOAD;
                  busy     <= 1'b1;
               end
            end
            COOK: begin
               if (cook_cnt == '0) state <= SERVE;
               else                cook_cnt <= cook_cnt - ONE;
            end
            SERVE: begin
               meal    <= 1'b1;
               state   <= WAIT;
               dly_cnt <= DLY_LOAD;
            end
            WAIT: begin
               if (dly_cnt == '0) state <= READ;
               else               dly_cnt <= dly_cnt - ONE;
            end
            READ: begin
               book  <= 1'b1;
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   // Pantry stock: deliveries add, meal starts consume, full pantry drops deliveries
   always_ff @(posedge clk or posedge resetb) begin
      if (resetb) begin
         pantry_cnt <= INIT_C;
         drop       <= 1'b0;
      end else begin
         drop <= groceries && !consume && full;
         if (groceries && !consume && !full)
            pantry_cnt <= pantry_cnt + ONE;
         else if (consume && !groceries)
            pantry_cnt <= pantry_cnt - ONE;
      end
   end

`ifdef STARVE_ALARM_EN
   localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

   logic [CNT_W-1:0] starve_cnt;
   logic             starve_cond;

   assign starve_cond = (state == IDLE) && request && (pantry_cnt == '0);

   // Starvation counter and sticky alarm, cleared by the next meal
   always_ff @(posedge clk or posedge resetb) begin
      if (resetb) begin
         starve_cnt <= '0;
         starving   <= 1'b0;
      end else begin
         if (!starve_cond)
            starve_cnt <= '0;
         else if (starve_cnt != '1)
            starve_cnt <= starve_cnt + ONE;
         if (meal)
            starving <= 1'b0;
         else if (starve_cnt >= LIMIT_C)
            starving <= 1'b1;
      end
   end
`else
   assign starving = 1'b0;
`endif

endmodule

// File: tb/tb_parent_server.sv
// Self-checking bench for parent_server: timeline-based reference model
// (meal/book/busy derived from the edge on which a meal started) plus
// an emulated kid for the closed-loop scenario.
`timescale 1ns/1ps
module tb_parent_server;

   localparam int COOK  = 4;
   localparam int BDLY  = 2;
   localparam int DEPTH = 3;
   localparam int INIT  = 1;
   localparam int CW    = 4;
   localparam int LIMIT = 8;
   // Edges from a meal start until the next start is possible
   localparam int CYCLE_LEN = COOK + BDLY + 3;

   logic          clk = 1'b0;
   logic          resetb = 1'b0;
   logic          request = 1'b0;
   logic          groceries = 1'b0;
   logic          meal, book, busy, drop, starving;
   logic [CW-1:0] pantry_cnt;

   int checks = 0;
   int errors = 0;

   // reference model state
   int   k = 0;
   int   m_start = -1000;
   int   m_stock = INIT;
   int   s_cnt = 0;
   logic e_meal = 1'b0, e_book = 1'b0, e_busy = 1'b0, e_drop = 1'b0, e_starv = 1'b0;

   parent_server #(
      .COOK_CYCLES(COOK), .BOOK_DELAY(BDLY), .PANTRY_DEPTH(DEPTH),
      .INIT_STOCK(INIT), .CNT_W(CW), .STARVE_LIMIT(LIMIT)
   ) dut (
      .clk(clk), .resetb(resetb), .request(request), .groceries(groceries),
      .meal(meal), .book(book), .pantry_cnt(pantry_cnt), .busy(busy),
      .drop(drop), .starving(starving)
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      m_start = -1000; m_stock = INIT; s_cnt = 0;
      e_meal = 0; e_book = 0; e_busy = 0; e_drop = 0; e_starv = 0;
   endtask

   // Drive one cycle of inputs and advance the model to the post-edge expectations
   task automatic step(input logic req, input logic groc);
      logic idle, cons;
      @(negedge clk);
      request = req; groceries = groc;
      @(posedge clk);
      k++;
      idle = (k >= m_start + CYCLE_LEN);
      cons = idle && req && (m_stock > 0);
`ifdef STARVE_ALARM_EN
      if (e_meal) e_starv = 1'b0;
      else if (s_cnt >= LIMIT) e_starv = 1'b1;
      if (idle && req && m_stock == 0) begin
         if (s_cnt < (2**CW) - 1) s_cnt++;
      end else s_cnt = 0;
`endif
      if (cons) m_start = k;
      e_drop = groc && !cons && (m_stock == DEPTH);
      if (cons && !groc) m_stock--;
      else if (groc && !cons && m_stock < DEPTH) m_stock++;
      e_busy = (k - m_start) <= (COOK + BDLY + 1);
      e_meal = (k == m_start + COOK + 1);
      e_book = (k == m_start + COOK + BDLY + 2);
      #1;
   endtask

   task automatic apply_reset();
      @(negedge clk);
      resetb = 1'b1; request = 1'b0; groceries = 1'b0;
      @(negedge clk);
      @(negedge clk);
      resetb = 1'b0;
      model_reset();
   endtask

   task automatic test_reset();
      resetb = 1'b0;
      #2 resetb = 1'b1;
      #3;
      checks++; if (pantry_cnt !== CW'(INIT)) begin errors++; $display("FAIL reset_pantry got %0d exp %0d", pantry_cnt, INIT); end
      checks++; if (meal !== 1'b0) begin errors++; $display("FAIL reset_meal got %b exp 0", meal); end
      checks++; if (book !== 1'b0) begin errors++; $display("FAIL reset_book got %b exp 0", book); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
      checks++; if (drop !== 1'b0) begin errors++; $display("FAIL reset_drop got %b exp 0", drop); end
      checks++; if (starving !== 1'b0) begin errors++; $display("FAIL reset_starving got %b exp 0", starving); end
      @(negedge clk);
      @(negedge clk);
      resetb = 1'b0;
      model_reset();
   endtask

   task automatic test_first_serve();
      int  cook_edge = -1, meal_edge = -1, book_edge = -1;
      logic seen_meal = 1'b0;
      step(1'b0, 1'b0);
      for (int i = 0; i < 14; i++) begin
         step(!seen_meal, 1'b0);
         if (busy === 1'b1 && cook_edge < 0) cook_edge = k;
         if (meal === 1'b1) begin meal_edge = k; seen_meal = 1'b1; end
         if (book === 1'b1) book_edge = k;
         checks++; if (busy !== e_busy) begin errors++; $display("FAIL first_busy k=%0d got %b exp %b", k, busy, e_busy); end
         checks++; if (meal !== e_meal) begin errors++; $display("FAIL first_meal k=%0d got %b exp %b", k, meal, e_meal); end
         checks++; if (book !== e_book) begin errors++; $display("FAIL first_book k=%0d got %b exp %b", k, book, e_book); end
         checks++; if (pantry_cnt !== CW'(m_stock)) begin errors++; $display("FAIL first_pantry k=%0d got %0d exp %0d", k, pantry_cnt, m_stock); end
      end
      checks++; if (meal_edge - cook_edge !== COOK + 1) begin errors++; $display("FAIL first_meal_latency got %0d exp %0d", meal_edge - cook_edge, COOK + 1); end
      checks++; if (book_edge - meal_edge !== BDLY + 1) begin errors++; $display("FAIL first_book_latency got %0d exp %0d", book_edge - meal_edge, BDLY + 1); end
   endtask

   task automatic test_empty_pantry();
      for (int i = 0; i < 20; i++) begin
         step(1'b1, 1'b0);
         checks++; if (meal !== 1'b0) begin errors++; $display("FAIL empty_meal k=%0d got %b exp 0", k, meal); end
         checks++; if (busy !== 1'b0) begin errors++; $display("FAIL empty_busy k=%0d got %b exp 0", k, busy); end
         checks++; if (starving !== e_starv) begin errors++; $display("FAIL empty_starving k=%0d got %b exp %b", k, starving, e_starv); end
      end
      step(1'b1, 1'b1);
      checks++; if (pantry_cnt !== CW'(1)) begin errors++; $display("FAIL empty_restock got %0d exp 1", pantry_cnt); end
      step(1'b1, 1'b0);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL empty_cook_start got %b exp 1", busy); end
      checks++; if (pantry_cnt !== CW'(0)) begin errors++; $display("FAIL empty_consume got %0d exp 0", pantry_cnt); end
      for (int i = 0; i < 12; i++) begin
         step(1'b0, 1'b0);
         checks++; if (meal !== e_meal) begin errors++; $display("FAIL empty_drain_meal k=%0d got %b exp %b", k, meal, e_meal); end
         checks++; if (starving !== e_starv) begin errors++; $display("FAIL empty_drain_starving k=%0d got %b exp %b", k, starving, e_starv); end
      end
   endtask

   task automatic test_pantry_full();
      logic reqs  [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      logic grocs [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
      apply_reset();
      for (int i = 0; i < 6; i++) begin
         step(reqs[i], grocs[i]);
         checks++; if (pantry_cnt !== CW'(m_stock)) begin errors++; $display("FAIL full_pantry i=%0d got %0d exp %0d", i, pantry_cnt, m_stock); end
         checks++; if (drop !== e_drop) begin errors++; $display("FAIL full_drop i=%0d got %b exp %b", i, drop, e_drop); end
         checks++; if (busy !== e_busy) begin errors++; $display("FAIL full_busy i=%0d got %b exp %b", i, busy, e_busy); end
      end
      for (int i = 0; i < 10; i++) step(1'b0, 1'b0);
   endtask

   task automatic test_reset_mid();
      apply_reset();
      step(1'b1, 1'b0);
      for (int i = 0; i < COOK + 2; i++) step(1'b0, 1'b0);
      #2 resetb = 1'b1;
      #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy got %b exp 0", busy); end
      checks++; if (pantry_cnt !== CW'(INIT)) begin errors++; $display("FAIL mid_pantry got %0d exp %0d", pantry_cnt, INIT); end
      checks++; if (meal !== 1'b0) begin errors++; $display("FAIL mid_meal got %b exp 0", meal); end
      @(negedge clk);
      @(negedge clk);
      resetb = 1'b0;
      model_reset();
      for (int i = 0; i < 10; i++) begin
         step(1'b0, 1'b0);
         checks++; if (book !== 1'b0) begin errors++; $display("FAIL mid_book k=%0d got %b exp 0", k, book); end
      end
   endtask

   task automatic test_random();
      logic r, g;
      apply_reset();
      for (int i = 0; i < 400; i++) begin
         r = ($urandom_range(0, 3) != 0);
         g = ($urandom_range(0, 4) == 0);
         step(r, g);
         checks++; if (meal !== e_meal) begin errors++; $display("FAIL rand_meal k=%0d got %b exp %b", k, meal, e_meal); end
         checks++; if (book !== e_book) begin errors++; $display("FAIL rand_book k=%0d got %b exp %b", k, book, e_book); end
         checks++; if (busy !== e_busy) begin errors++; $display("FAIL rand_busy k=%0d got %b exp %b", k, busy, e_busy); end
         checks++; if (drop !== e_drop) begin errors++; $display("FAIL rand_drop k=%0d got %b exp %b", k, drop, e_drop); end
         checks++; if (pantry_cnt !== CW'(m_stock)) begin errors++; $display("FAIL rand_pantry k=%0d got %0d exp %0d", k, pantry_cnt, m_stock); end
         checks++; if (starving !== e_starv) begin errors++; $display("FAIL rand_starving k=%0d got %b exp %b", k, starving, e_starv); end
      end
   endtask

   task automatic test_kid_loop();
      logic hungry = 1'b1, got_meal = 1'b0;
      int   study = 0, meals = 0, books = 0;
      apply_reset();
      for (int i = 0; i < 300; i++) begin
         step(hungry, (i % 10) == 0);
         checks++; if (meal !== e_meal) begin errors++; $display("FAIL kid_meal k=%0d got %b exp %b", k, meal, e_meal); end
         checks++; if (book !== e_book) begin errors++; $display("FAIL kid_book k=%0d got %b exp %b", k, book, e_book); end
         checks++; if (pantry_cnt !== CW'(m_stock)) begin errors++; $display("FAIL kid_pantry k=%0d got %0d exp %0d", k, pantry_cnt, m_stock); end
         if (meal === 1'b1) begin
            checks++; if (got_meal !== 1'b0) begin errors++; $display("FAIL kid_double_meal k=%0d got 2 meals exp 1", k); end
            got_meal = 1'b1; hungry = 1'b0; meals++;
         end
         if (book === 1'b1) begin
            checks++; if (got_meal !== 1'b1) begin errors++; $display("FAIL kid_book_order k=%0d got book without meal exp meal first", k); end
            got_meal = 1'b0; books++;
            study = $urandom_range(1, 5);
         end else if (!hungry && !got_meal) begin
            if (study > 0) study--;
            if (study == 0) hungry = 1'b1;
         end
      end
      checks++; if (meals < 10) begin errors++; $display("FAIL kid_meal_count got %0d exp >=10", meals); end
      checks++; if (meals - books > 1 || meals < books) begin errors++; $display("FAIL kid_alternation got meals=%0d books=%0d exp equal or one ahead", meals, books); end
   endtask

   initial begin
      test_reset();
      test_first_serve();
      test_empty_pantry();
      test_pantry_full();
      test_reset_mid();
      test_random();
      test_kid_loop();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
